// File: rtl/relu_forward_if.sv
// ---------------------------------------------------------------------------
// relu_forward_if
// Memory handle used by the forward ReLU stage. The block holds the master
// side of one handle for the source tensor and one for the destination.
//
// Signals (master = block, slave = memory):
//   r_en, w_en     read / write enable            (master -> slave)
//   avail          request valid, mirrors enable  (master -> slave)
//   ptr            word address                   (master -> slave)
//   data_store     write data                     (master -> slave)
//   write_through  marks the last tensor write    (master -> slave)
//   data_load      read data                      (slave -> master)
//   done           access completed this cycle    (slave -> master)
//   region_begin   first word of the tensor       (slave -> master)
//   region_end     one past the last tensor word  (slave -> master)
// ---------------------------------------------------------------------------
interface relu_forward_if #(
   parameter int PTR_W = 16
);
   logic             r_en;
   logic             w_en;
   logic             avail;
   logic [PTR_W-1:0] ptr;
   logic [31:0]      data_store;
   logic             write_through;
   logic [31:0]      data_load;
   logic             done;
   logic [PTR_W-1:0] region_begin;
   logic [PTR_W-1:0] region_end;

   modport master (
      output r_en, w_en, avail, ptr, data_store, write_through,
      input  data_load, done, region_begin, region_end
   );

   modport slave (
      input  r_en, w_en, avail, ptr, data_store, write_through,
      output data_load, done, region_begin, region_end
   );
endinterface

// File: rtl/relu_forward.sv
// ---------------------------------------------------------------------------
// relu_forward
// Forward ReLU stage. Copies the tensor header from handle a to handle d
// unchanged, then streams every element X from a and writes
// Y = max(X, +0.0) to d. Any element with the sign bit set (including -0.0
// and negative NaN) is written as +0.0.
//
// Ports:
//   clk        rising-edge clock
//   rst_l      asynchronous active-low reset
//   a          source tensor handle (reads only)
//   d          destination tensor handle (writes only)
//   go         level start request, sampled in WAIT and DONE only
//   done       high while the stage sits in DONE
//   neg_count  number of negative elements seen in the last pass
//              (only when RELU_FWD_NEG_COUNT_EN is defined)
//
// Optional feature macro: RELU_FWD_NEG_COUNT_EN
// ---------------------------------------------------------------------------
module relu_forward #(
   parameter int HDR_MAX = 3,
   parameter int PTR_W   = 16
) (
   input  logic           clk,
   input  logic           rst_l,
   relu_forward_if.master a,
   relu_forward_if.master d,
   input  logic           go,
   output logic           done
`ifdef RELU_FWD_NEG_COUNT_EN
   ,
   output logic [31:0]    neg_count
`endif
);

   typedef enum logic [2:0] {
      WAIT,
      START,
      HDR_RD,
      HDR_WR,
      LOOP,
      RD,
      WR,
      DONE
   } state_t;

   localparam logic [PTR_W-1:0] PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       HDR_LEN_1D  = 2'd2;
   localparam logic [1:0]       HDR_LEN_ND  = 2'(HDR_MAX);

   state_t           state;
   state_t           state_next;
   logic [31:0]      hbuf;
   logic [31:0]      x;
   logic [31:0]      y;
   logic [1:0]       hdr_cnt;
   logic [1:0]       hdr_len;
   logic [PTR_W-1:0] a_ptr;
   logic [PTR_W-1:0] d_ptr;
   logic             unused_inputs;

   assign unused_inputs = ^{a.region_end, d.data_load};

   // Any element with the sign bit set becomes +0.0, which also folds
   // -0.0 and negative NaNs onto +0.0.
   assign y = x[31] ? 32'h0000_0000 : x;

   // State register. Reset drops straight back to WAIT so a transfer in
   // flight is abandoned without finishing its current write.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Each memory access lives in its own state and the
   // state is left in the cycle the memory reports done, so enables drop
   // with the transition. The header loop runs until hdr_len words have
   // been copied; the element loop stops when d has reached region_end,
   // which also covers the empty tensor.
   always_comb begin
      state_next = state;
      case (state)
         WAIT:    if (go) state_next = START;
         START:   state_next = HDR_RD;
         HDR_RD:  if (a.done) state_next = HDR_WR;
         HDR_WR: begin
            if (d.done) begin
               if (hdr_cnt + 2'd1 == hdr_len) state_next = LOOP;
               else                           state_next = HDR_RD;
            end
         end
         LOOP:    state_next = (d_ptr == d.region_end) ? DONE : RD;
         RD:      if (a.done) state_next = WR;
         WR:      if (d.done) state_next = LOOP;
         DONE:    if (!go) state_next = WAIT;
         default: state_next = WAIT;
      endcase
   end

   // Datapath registers: pointers, header bookkeeping and the captured
   // read words. Pointers advance by one in the cycle each access
   // completes. The header length comes from the ndims word, which is
   // always the first header word read.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         a_ptr   <= '0;
         d_ptr   <= '0;
         hbuf    <= '0;
         x       <= '0;
         hdr_cnt <= '0;
         hdr_len <= '0;
      end else begin
         case (state)
            START: begin
               a_ptr   <= a.region_begin;
               d_ptr   <= d.region_begin;
               hdr_cnt <= '0;
            end
            HDR_RD: begin
               if (a.done) begin
                  hbuf  <= a.data_load;
                  a_ptr <= a_ptr + PTR_ONE;
                  if (hdr_cnt == 2'd0) begin
                     hdr_len <= (a.data_load == 32'd1) ? HDR_LEN_1D : HDR_LEN_ND;
                  end
               end
            end
            HDR_WR: begin
               if (d.done) begin
                  d_ptr   <= d_ptr + PTR_ONE;
                  hdr_cnt <= hdr_cnt + 2'd1;
               end
            end
            RD: begin
               if (a.done) begin
                  x     <= a.data_load;
                  a_ptr <= a_ptr + PTR_ONE;
               end
            end
            WR: begin
               if (d.done) begin
                  d_ptr <= d_ptr + PTR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RELU_FWD_NEG_COUNT_EN
   // Negative-element counter. Cleared at the start of each pass, bumped
   // when a negative element's write completes, saturating at all ones,
   // and left untouched afterwards so it can be read in DONE or WAIT.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         neg_count <= '0;
      end else if (state == START) begin
         neg_count <= '0;
      end else if (state == WR && d.done && x[31] && neg_count != 32'hFFFF_FFFF) begin
         neg_count <= neg_count + 32'd1;
      end
   end
`endif

   // Handle outputs decoded from the current state. Enable and avail
   // are the same request, so they rise and fall together. Write data
   // comes straight from the captured word, which cannot change while
   // the write state is held. write_through is only possible in the
   // element write state and only for the last destination word.
   always_comb begin
      a.r_en          = (state == HDR_RD) || (state == RD);
      a.avail         = a.r_en;
      a.w_en          = 1'b0;
      a.ptr           = a_ptr;
      a.data_store    = 32'h0000_0000;
      a.write_through = 1'b0;

      d.r_en          = 1'b0;
      d.w_en          = (state == HDR_WR) || (state == WR);
      d.avail         = d.w_en;
      d.ptr           = d_ptr;
      d.data_store    = 32'h0000_0000;
      d.write_through = 1'b0;

      if (state == HDR_WR) begin
         d.data_store = hbuf;
      end else if (state == WR) begin
         d.data_store    = y;
         d.write_through = (d_ptr == d.region_end - PTR_ONE);
      end

      done = (state == DONE);
   end

endmodule
